float_copro_queue: RTL and testbench

Queued floating-point coprocessor for the LM32 copro port. It accepts commands into a command FIFO, runs them one at a time through the combinational `float_copro_dp` datapath, and uses a per-opcode multicycle count to decide when each result is ready. Results are held in a result FIFO until the CPU accepts them, so the CPU can issue several operations before collecting any results. Latencies and FIFO depths are parameters.

---
 rtl/float_copro_queue_if.sv | 29 ++
 rtl/float_copro_queue.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_float_copro_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/float_copro_queue_if.sv
// float_copro_queue_if
//   Bundles the LM32 coprocessor handshake between the CPU and the queued
//   floating-point coprocessor.
//   Command side : copro_valid/copro_ready handshake carrying opcode, op0, op1.
//   Result side  : copro_complete/copro_accept handshake carrying result, error.
//   Status       : copro_busy (command queued or executing).
//   master = CPU side, slave = coprocessor side.
interface float_copro_queue_if;
    logic        copro_valid;
    logic        copro_ready;
    logic [10:0] copro_opcode;
    logic [31:0] copro_op0;
    logic [31:0] copro_op1;
    logic        copro_complete;
    logic [31:0] copro_result;
    logic        copro_error;
    logic        copro_accept;
    logic        copro_busy;

    modport master (
        output copro_valid, copro_opcode, copro_op0, copro_op1, copro_accept,
        input  copro_ready, copro_complete, copro_result, copro_error, copro_busy
    );

    modport slave (
        input  copro_valid, copro_opcode, copro_op0, copro_op1, copro_accept,
        output copro_ready, copro_complete, copro_result, copro_error, copro_busy
    );
endinterface

// File: rtl/float_copro_queue.sv
// float_copro_dp
//   Combinational IEEE-754 single-precision add/sub/mult/div.
//   op : 0=add 1=sub 2=mult 3=div;  a, b : operands;  y : result.
//   Round to nearest even; subnormal inputs and results flush to zero;
//   every NaN result is the quiet NaN 0x7FC00000.
//
// float_copro_queue
//   Queued coprocessor: command FIFO -> IDLE/BUSY executor with per-opcode
//   multicycle latency around float_copro_dp -> result FIFO.
//   clk, reset_n (async, active low); bus = float_copro_queue_if.slave.
module float_copro_dp (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // m[26] is the leading one, m[2] guard, m[1:0] round/sticky.
    function automatic logic [31:0] pack(input logic s, input logic signed [10:0] e,
                                         input logic [26:0] m);
        logic [24:0]        mr;
        logic signed [10:0] ee;
        logic               up;
        up = m[2] & (m[3] | m[1] | m[0]);
        mr = {1'b0, m[26:3]} + {24'd0, up};
        ee = e;
        if (mr[24]) begin
            mr = mr >> 1;
            ee = ee + 11'sd1;
        end
        if (ee >= 11'sd255)
            return {s, 8'hFF, 23'd0};
        if (ee <= 11'sd0)
            return {s, 31'd0};
        return {s, ee[7:0], 23'(mr)};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x0, input logic [31:0] y0);
        logic [31:0]        x, v;
        logic [7:0]         d;
        logic [26:0]        mx, my, ys, m;
        logic               sticky;
        logic [27:0]        sum;
        logic signed [10:0] e;
        int unsigned        lz;
        // Larger magnitude first: its sign is the result sign.
        if (x0[30:0] >= y0[30:0]) begin
            x = x0; v = y0;
        end else begin
            x = y0; v = x0;
        end
        if (x[30:23] == 8'd0)
            return {x0[31] & y0[31], 31'd0};
        if (v[30:23] == 8'd0)
            return x;
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, v[22:0], 3'b000};
        d  = x[30:23] - v[30:23];
        ys = my >> d;
        sticky = |(my & ~(27'h7FF_FFFF << d));
        ys[0] = ys[0] | sticky;
        sum = (x[31] ^ v[31]) ? ({1'b0, mx} - {1'b0, ys}) : ({1'b0, mx} + {1'b0, ys});
        e = signed'({3'b000, x[30:23]});
        if (sum == 28'd0)
            return 32'd0;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 11'sd1;
        end else begin
            lz = 0;
            for (int unsigned i = 0; i < 27; i++)
                if (sum[i]) lz = 26 - i;
            m = sum[26:0] << lz;
            e = e - signed'(11'(lz));
        end
        return pack(x[31], e, m);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] v);
        logic [47:0]        p;
        logic [26:0]        m;
        logic signed [10:0] e;
        if (x[30:23] == 8'd0 || v[30:23] == 8'd0)
            return {x[31] ^ v[31], 31'd0};
        p = {1'b1, x[22:0]} * {1'b1, v[22:0]};
        e = signed'({3'b000, x[30:23]}) + signed'({3'b000, v[30:23]}) - 11'sd127;
        if (p[47]) begin
            m = {p[47:22], |p[21:0]};
            e = e + 11'sd1;
        end else begin
            m = {p[46:21], |p[20:0]};
        end
        return pack(x[31] ^ v[31], e, m);
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] x, input logic [31:0] v);
        logic [50:0]        num, den;
        logic [27:0]        q;
        logic [23:0]        r;
        logic [26:0]        m;
        logic signed [10:0] e;
        if (x[30:23] == 8'd0)
            return {x[31] ^ v[31], 31'd0};
        // Quotient of the significands scaled by 2^27; leading one at bit 27 or 26.
        num = {1'b1, x[22:0], 27'd0};
        den = {27'd0, 1'b1, v[22:0]};
        q   = 28'(num / den);
        r   = 24'(num % den);
        e   = signed'({3'b000, x[30:23]}) - signed'({3'b000, v[30:23]}) + 11'sd127;
        if (q[27]) begin
            m = {q[27:2], q[1] | q[0] | (r != 24'd0)};
        end else begin
            m = {q[26:1], q[0] | (r != 24'd0)};
            e = e - 11'sd1;
        end
        return pack(x[31] ^ v[31], e, m);
    endfunction

    logic [31:0] bb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;

    assign bb     = (op == 2'd1) ? {~b[31], b[30:0]} : b;
    assign a_nan  = (&a[30:23]) && (|a[22:0]);
    assign b_nan  = (&b[30:23]) && (|b[22:0]);
    assign a_inf  = (&a[30:23]) && !(|a[22:0]);
    assign b_inf  = (&b[30:23]) && !(|b[22:0]);
    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);
    assign sgn    = a[31] ^ b[31];

    always_comb begin
        y = QNAN;
        case (op)
            2'd0, 2'd1: begin
                if (a_nan || b_nan || (a_inf && b_inf && (a[31] != bb[31]))) y = QNAN;
                else if (a_inf)                                              y = a;
                else if (b_inf)                                              y = bb;
                else                                                         y = fadd(a, bb);
            end
            2'd2: begin
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = QNAN;
                else if (a_inf || b_inf) y = {sgn, 8'hFF, 23'd0};
                else                     y = fmul(a, b);
            end
            default: begin
                if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) y = QNAN;
                else if (a_inf || b_zero) y = {sgn, 8'hFF, 23'd0};
                else if (b_inf)           y = {sgn, 31'd0};
                else                      y = fdiv(a, b);
            end
        endcase
    end
endmodule

module float_copro_queue #(
    parameter int T_ADD     = 3,
    parameter int T_SUB     = 3,
    parameter int T_MULT    = 2,
    parameter int T_DIV     = 12,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    float_copro_queue_if.slave bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_FULL  = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0] RES_FULL  = (RAW+1)'(RES_DEPTH);
    localparam logic [RAW:0] RES_CHAIN = (RAW+1)'(RES_DEPTH - 2);
    localparam logic [0:0]   ST_IDLE   = 1'b0;
    localparam logic [0:0]   ST_BUSY   = 1'b1;

    function automatic logic [15:0] latency(input logic [10:0] op);
        case (op)
            11'd0:   return 16'(T_ADD);
            11'd1:   return 16'(T_SUB);
            11'd2:   return 16'(T_MULT);
            11'd3:   return 16'(T_DIV);
            default: return 16'd1;
        endcase
    endfunction

    logic [10:0]    cmd_opc [CMD_DEPTH];
    logic [31:0]    cmd_a   [CMD_DEPTH];
    logic [31:0]    cmd_b   [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr, cmd_rd;
    logic [CAW:0]   cmd_cnt;

    logic [31:0]    res_val [RES_DEPTH];
    logic           res_err [RES_DEPTH];
    logic [RAW-1:0] res_wr, res_rd;
    logic [RAW:0]   res_cnt;

    logic [0:0]     state;
    logic [15:0]    cnt;
    logic [10:0]    opc_r;
    logic [31:0]    a_r, b_r;
    logic [31:0]    dp_y, res_data;
    logic           illegal;
    logic           cmd_push, cmd_pop, res_push, res_pop, start, done, chain;

    float_copro_dp u_dp (
        .op (opc_r[1:0]),
        .a  (a_r),
        .b  (b_r),
        .y  (dp_y)
    );

    assign illegal  = (opc_r > 11'd3);
    assign res_data = illegal ? 32'h7FC0_0000 : dp_y;

    assign cmd_push = bus.copro_valid && (cmd_cnt != CMD_FULL);
    assign res_pop  = bus.copro_accept && (res_cnt != '0);
    // Space checks use the pre-edge result count, so a same-edge accept never
    // lets a new command start; chaining needs room for the result being
    // written now plus the next one.
    assign start    = (state == ST_IDLE) && (cmd_cnt != '0) && (res_cnt < RES_FULL);
    assign done     = (state == ST_BUSY) && (cnt == 16'd1);
    assign chain    = done && (cmd_cnt != '0) && (res_cnt <= RES_CHAIN);
    assign cmd_pop  = start || chain;
    assign res_push = done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opc_r <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (cmd_pop) begin
            state <= ST_BUSY;
            cnt   <= latency(cmd_opc[cmd_rd]);
            opc_r <= cmd_opc[cmd_rd];
            a_r   <= cmd_a[cmd_rd];
            b_r   <= cmd_b[cmd_rd];
        end else if (state == ST_BUSY) begin
            if (done) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt   <= cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_wr  <= '0;
            cmd_rd  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
            if (cmd_pop)  cmd_rd <= cmd_rd + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_opc[cmd_wr] <= bus.copro_opcode;
            cmd_a[cmd_wr]   <= bus.copro_op0;
            cmd_b[cmd_wr]   <= bus.copro_op1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_wr  <= '0;
            res_rd  <= '0;
            res_cnt <= '0;
        end else begin
            if (res_push) res_wr <= res_wr + 1'b1;
            if (res_pop)  res_rd <= res_rd + 1'b1;
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res_push) begin
            res_val[res_wr] <= res_data;
            res_err[res_wr] <= illegal;
        end
    end

    // Result storage is not reset; the head is masked while the FIFO is empty.
    assign bus.copro_ready    = (cmd_cnt != CMD_FULL);
    assign bus.copro_busy     = (state == ST_BUSY) || (cmd_cnt != '0);
    assign bus.copro_complete = (res_cnt != '0);
    assign bus.copro_result   = (res_cnt != '0) ? res_val[res_rd] : '0;
    assign bus.copro_error    = (res_cnt != '0) && res_err[res_rd];
endmodule

// File: tb/tb_float_copro_queue.sv
// tb_float_copro_queue
//   Directed stimulus for float_copro_queue. Issued commands push their
//   hand-computed {error, result} into a scoreboard queue; a monitor pops and
//   compares on every result handshake. Latency/status checks are inline.
module tb_float_copro_queue;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    float_copro_queue_if bus();

    float_copro_queue #(
        .T_ADD(3), .T_SUB(3), .T_MULT(2), .T_DIV(12), .CMD_DEPTH(4), .RES_DEPTH(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pops     = 0;
    logic        saw_nr   = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] e_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a result handshake seen at the falling edge pops at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && bus.copro_complete && bus.copro_accept) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%h err=%b required=none", bus.copro_result, bus.copro_error);
            end else begin
                e_v = exp_q.pop_front();
                if ({bus.copro_error, bus.copro_result} !== e_v) begin
                    failures++;
                    $display("FAIL pop_result got=%b_%h required=%b_%h", bus.copro_error,
                             bus.copro_result, e_v[32], e_v[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic issue(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] ex, output int hs);
        int w;
        bus.copro_valid  = 1'b1;
        bus.copro_opcode = op;
        bus.copro_op0    = a;
        bus.copro_op1    = b;
        w = 0;
        @(negedge clk);
        while (!bus.copro_ready && w < 200) begin
            saw_nr = 1'b1;
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout got=ready_low required=ready_high");
        end
        @(posedge clk);
        #1;
        hs = cyc;
        if (w < 200) exp_q.push_back(ex);
        bus.copro_valid = 1'b0;
    endtask

    task automatic wait_complete(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.copro_complete) begin
                c = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int n);
        int target, w;
        target = pops + n;
        w = 0;
        bus.copro_accept = 1'b1;
        while (pops < target && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        bus.copro_accept = 1'b0;
        chk("drain_count", pops, target);
    endtask

    logic [31:0] bp_a   [7] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};
    logic [31:0] bp_sum [7] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
                                32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

    initial begin
        #200000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs0, c, bl, p0;
        bus.copro_valid  = 1'b0;
        bus.copro_opcode = '0;
        bus.copro_op0    = '0;
        bus.copro_op1    = '0;
        bus.copro_accept = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_ready",    bus.copro_ready,    1);
        chk("rst_complete", bus.copro_complete, 0);
        chk("rst_result",   bus.copro_result,   0);
        chk("rst_error",    bus.copro_error,    0);
        chk("rst_busy",     bus.copro_busy,     0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add: 1.5 + 2.25 = 3.75
        issue(11'd0, 32'h3FC0_0000, 32'h4010_0000, {1'b0, 32'h4070_0000}, hs);
        wait_complete(c);
        chk("add_latency", c - hs, 4);
        chk("add_head", bus.copro_result, 32'h4070_0000);
        drain(1);
        chk("add_complete_clear", bus.copro_complete, 0);

        // Mixed burst: 2*3, 1/4, 5-1
        issue(11'd2, 32'h4000_0000, 32'h4040_0000, {1'b0, 32'h40C0_0000}, hs0);
        issue(11'd3, 32'h3F80_0000, 32'h4080_0000, {1'b0, 32'h3E80_0000}, hs);
        issue(11'd1, 32'h40A0_0000, 32'h3F80_0000, {1'b0, 32'h4080_0000}, hs);
        c  = bus.copro_complete ? cyc : -1;
        bl = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (c < 0 && bus.copro_complete) c = cyc;
            if (!bus.copro_busy) begin
                bl = cyc;
                break;
            end
        end
        chk("burst_first_complete", c - hs0, 3);
        chk("burst_busy_fall", bl - hs0, 18);
        drain(3);

        // Illegal opcode, then an add behind it: 1 + 1 = 2
        issue(11'd5, 32'h3F80_0000, 32'h3F80_0000, {1'b1, 32'h7FC0_0000}, hs);
        wait_complete(c);
        chk("illegal_latency", c - hs, 2);
        chk("illegal_error", bus.copro_error, 1);
        issue(11'd0, 32'h3F80_0000, 32'h3F80_0000, {1'b0, 32'h4000_0000}, hs);
        repeat (10) @(posedge clk);
        #1;
        drain(2);

        // Backpressure: seven adds, nothing accepted until the pipe stalls
        saw_nr = 1'b0;
        for (int i = 0; i < 7; i++)
            issue(11'd0, bp_a[i], 32'h3F80_0000, {1'b0, bp_sum[i]}, hs);
        chk("bp_ready_dropped", saw_nr, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("bp_stall_complete", bus.copro_complete, 1);
        chk("bp_stall_busy", bus.copro_busy, 1);
        // Three commands parked in a four-entry queue.
        chk("bp_stall_ready", bus.copro_ready, 1);
        drain(7);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_idle_busy", bus.copro_busy, 0);
        chk("bp_idle_complete", bus.copro_complete, 0);

        // Accept on the same edge as the fourth result write (three already held)
        issue(11'd0, 32'h3F00_0000, 32'h3F00_0000, {1'b0, 32'h3F80_0000}, hs0);
        issue(11'd0, 32'h3FC0_0000, 32'h3E80_0000, {1'b0, 32'h3FE0_0000}, hs);
        issue(11'd0, 32'h4120_0000, 32'hC000_0000, {1'b0, 32'h4100_0000}, hs);
        issue(11'd1, 32'h4040_0000, 32'h3F00_0000, {1'b0, 32'h4020_0000}, hs);
        while (cyc < hs0 + 12) begin
            @(posedge clk);
            #1;
        end
        chk("simul_pre_complete", bus.copro_complete, 1);
        p0 = pops;
        bus.copro_accept = 1'b1;
        @(posedge clk);
        #1;
        bus.copro_accept = 1'b0;
        chk("simul_one_pop", pops - p0, 1);
        chk("simul_post_complete", bus.copro_complete, 1);
        drain(3);
        chk("simul_empty", bus.copro_complete, 0);

        // Asynchronous reset mid-BUSY with two results held
        issue(11'd0, 32'h3F80_0000, 32'h3F80_0000, {1'b0, 32'h4000_0000}, hs0);
        issue(11'd0, 32'h4000_0000, 32'h3F80_0000, {1'b0, 32'h4040_0000}, hs);
        issue(11'd0, 32'h4040_0000, 32'h3F80_0000, {1'b0, 32'h4080_0000}, hs);
        issue(11'd0, 32'h4080_0000, 32'h3F80_0000, {1'b0, 32'h40A0_0000}, hs);
        while (cyc < hs0 + 8) begin
            @(posedge clk);
            #1;
        end
        chk("prerst_complete", bus.copro_complete, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_complete", bus.copro_complete, 0);
        chk("midrst_busy",     bus.copro_busy,     0);
        chk("midrst_ready",    bus.copro_ready,    1);
        chk("midrst_result",   bus.copro_result,   0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("postrst_complete", bus.copro_complete, 0);
        chk("postrst_busy",     bus.copro_busy,     0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
